// File: rtl/ppa_sub_pipe.sv
// ---------------------------------------------------------------------------
// ppa_sub_pipe
//   Pipelined WIDTH-bit Kogge-Stone subtractor: diff = a - b - bin, and
//   bout = unsigned borrow out. It is computed as a + ~b + ~bin. It has three
//   register stages and valid/ready handshakes on both sides.
//
//   S1 : p/g/carry-in after pre-processing
//   S2 : group generate/propagate after ceil(rows/2) prefix rows
//   S3 : diff/bout after the remaining rows and post-processing
//
// Optional feature macro: PPA_SUB_FLAGS_EN
//   When this macro is defined, the zero and ovf outputs exist. zero is
//   (diff == 0). ovf is the signed overflow
//   (a_msb ^ b_msb) & (a_msb ^ diff_msb).
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      pair accepted this cycle when in_valid is high
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result this cycle
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      1 when a < b + bin
//   zero       out  1      (PPA_SUB_FLAGS_EN only) diff == 0
//   ovf        out  1      (PPA_SUB_FLAGS_EN only) signed overflow
// ---------------------------------------------------------------------------
module ppa_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef PPA_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int ROWS    = $clog2(WIDTH);
  localparam int ROWS_S1 = (ROWS + 1) / 2;

  // All stages move together. An empty stage still consumes one advance.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- pre-processing ----------------
  logic [WIDTH-1:0] b_n, pre_p, pre_g, pre_gf;
  logic             pre_cin;

  assign b_n     = ~b;
  assign pre_p   = a ^ b_n;
  assign pre_g   = a & b_n;
  assign pre_cin = ~bin;
  // The carry-in cell (g = ~bin, p = 0) is folded into bit 0 here. This lets
  // the prefix tree cover exactly WIDTH bits, using log2(WIDTH) rows.
  assign pre_gf  = {pre_g[WIDTH-1:1], pre_g[0] | (pre_p[0] & pre_cin)};

  // ---------------- stage registers ----------------
  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] p1_q, g1_q;
  logic             cin1_q;
  logic [WIDTH-1:0] p2_q, gg2_q, pp2_q;
  logic             cin2_q;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // ---------------- prefix rows ----------------
  // Rows below ROWS_S1 take their input from S1. Row ROWS_S1 restarts from
  // the S2 registers. Every other row chains from the row before it.
  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : gen_row
      localparam int DIST = 1 << gi;
      logic [WIDTH-1:0] g_in, p_in, g_out, p_out;

      if (gi == 0) begin : gen_src_s1
        assign g_in = g1_q;
        // Bit 0 now holds the carry-in node, so its propagate is 0.
        assign p_in = {p1_q[WIDTH-1:1], 1'b0};
      end else if (gi == ROWS_S1) begin : gen_src_s2
        assign g_in = gg2_q;
        assign p_in = pp2_q;
      end else begin : gen_src_prev
        assign g_in = gen_row[gi-1].g_out;
        assign p_in = gen_row[gi-1].p_out;
      end

      for (gj = 0; gj < WIDTH; gj++) begin : gen_bit
        if (gj >= DIST) begin : gen_black
          assign g_out[gj] = g_in[gj] | (p_in[gj] & g_in[gj-DIST]);
          assign p_out[gj] = p_in[gj] & p_in[gj-DIST];
        end else begin : gen_pass
          assign g_out[gj] = g_in[gj];
          assign p_out[gj] = p_in[gj];
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] g_mid, p_mid, g_fin;
  logic             unused_p_fin;

  assign g_mid        = gen_row[ROWS_S1-1].g_out;
  assign p_mid        = gen_row[ROWS_S1-1].p_out;
  assign g_fin        = gen_row[ROWS-1].g_out;
  // No row uses the propagate output of the last row.
  assign unused_p_fin = ^gen_row[ROWS-1].p_out;

  // ---------------- post-processing ----------------
  // G_{i-1} is the carry into bit i. For bit 0 the carry in is cin.
  always_comb begin
    diff_d = p2_q ^ {g_fin[WIDTH-2:0], cin2_q};
    bout_d = ~g_fin[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p1_q   <= '0;
      g1_q   <= '0;
      cin1_q <= 1'b0;
      p2_q   <= '0;
      gg2_q  <= '0;
      pp2_q  <= '0;
      cin2_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (advance) begin
      v1_q   <= in_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      p1_q   <= pre_p;
      g1_q   <= pre_gf;
      cin1_q <= pre_cin;
      p2_q   <= p1_q;
      gg2_q  <= g_mid;
      pp2_q  <= p_mid;
      cin2_q <= cin1_q;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

`ifdef PPA_SUB_FLAGS_EN
  logic amsb1_q, bmsb1_q, amsb2_q, bmsb2_q;
  logic zero_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      amsb1_q <= 1'b0;
      bmsb1_q <= 1'b0;
      amsb2_q <= 1'b0;
      bmsb2_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      amsb1_q <= a[WIDTH-1];
      bmsb1_q <= b[WIDTH-1];
      amsb2_q <= amsb1_q;
      bmsb2_q <= bmsb1_q;
      zero_q  <= (diff_d == '0);
      ovf_q   <= (amsb2_q ^ bmsb2_q) & (amsb2_q ^ diff_d[WIDTH-1]);
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule
